// File: rtl/spi_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_pkg
// Purpose  : Shared types and constants for the SPI register bridge.
// Revision : 1.0 - initial release
// ============================================================================
package spi_reg_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      WRITE   = 3'd2,
      RD_REQ  = 3'd3,
      RD_LOAD = 3'd4,
      RD_WAIT = 3'd5
   } state_t;

   localparam int         CMD_WR_BIT    = 7;
   localparam logic [7:0] DEF_IDLE_BYTE = 8'h00;

endpackage
`default_nettype wire

// File: rtl/spi_reg_bridge_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Single-bit two-flop synchronizer with selectable reset value.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_bridge
// Purpose  : Decodes SPI command/data bytes into register reads and writes.
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_bridge
   import spi_reg_pkg::*;
#(
   parameter int         ADDR_WIDTH = 7,
   parameter int         AUTO_INC   = 1,
   parameter logic [7:0] IDLE_BYTE  = DEF_IDLE_BYTE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ss,
   input  logic [7:0]            rx_byte,
   input  logic                  rx_dv,
   output logic [7:0]            tx_byte,
   output logic                  tx_wr,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [7:0]            reg_wdata,
   output logic                  reg_we,
   output logic                  reg_re,
   input  logic [7:0]            reg_rdata,
   output logic                  busy
);

   state_t                state, state_nxt;
   logic                  ss_n_s, ss_prev;
   logic [1:0]            settle_cnt;
   logic                  settled, ss_fall, ss_rise;
   logic [ADDR_WIDTH-1:0] addr_inc, addr_nxt;
   logic [7:0]            wdata_nxt, tx_hold, tx_hold_nxt;
   logic                  we_nxt, re_nxt, tx_wr_nxt;

   sync_2ff #(.RST_VAL(1'b1)) u_ss_sync (
      .clk (clk),
      .rst (rst),
      .d   (ss),
      .q   (ss_n_s)
   );

   // The synchronizer comes out of reset at 1; if ss is already low, its first
   // drop is the tail of a frame in progress and must not start a transaction.
   assign settled  = &settle_cnt;
   assign ss_fall  = settled & ss_prev & ~ss_n_s;
   assign ss_rise  = ~ss_prev & ss_n_s;
   assign addr_inc = reg_addr + ADDR_WIDTH'(1);
   assign busy     = (state != IDLE);
   // Read data is forwarded combinationally so tx_wr can land with it.
   assign tx_byte  = (state == RD_LOAD) ? reg_rdata : tx_hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ss_prev    <= 1'b1;
         settle_cnt <= 2'd0;
         reg_addr   <= '0;
         reg_wdata  <= 8'h00;
         reg_we     <= 1'b0;
         reg_re     <= 1'b0;
         tx_wr      <= 1'b0;
         tx_hold    <= 8'h00;
      end else begin
         state      <= state_nxt;
         ss_prev    <= ss_n_s;
         if (!settled) begin
            settle_cnt <= settle_cnt + 2'd1;
         end
         reg_addr   <= addr_nxt;
         reg_wdata  <= wdata_nxt;
         reg_we     <= we_nxt;
         reg_re     <= re_nxt;
         tx_wr      <= tx_wr_nxt;
         tx_hold    <= tx_hold_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      addr_nxt    = reg_addr;
      wdata_nxt   = reg_wdata;
      we_nxt      = 1'b0;
      re_nxt      = 1'b0;
      tx_wr_nxt   = 1'b0;
      tx_hold_nxt = tx_hold;
      if (ss_rise) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (ss_fall) begin
                  state_nxt   = CMD;
                  tx_wr_nxt   = 1'b1;
                  tx_hold_nxt = IDLE_BYTE;
               end
            end
            CMD: begin
               if (rx_dv) begin
                  addr_nxt = rx_byte[ADDR_WIDTH-1:0];
                  if (rx_byte[CMD_WR_BIT]) begin
                     state_nxt = WRITE;
                  end else begin
                     state_nxt = RD_REQ;
                     re_nxt    = 1'b1;
                  end
               end
            end
            WRITE: begin
               // Advance once the write strobe has been presented at this address.
               if (reg_we && (AUTO_INC != 0)) begin
                  addr_nxt = addr_inc;
               end
               if (rx_dv) begin
                  we_nxt    = 1'b1;
                  wdata_nxt = rx_byte;
               end
            end
            RD_REQ: begin
               state_nxt = RD_LOAD;
               tx_wr_nxt = 1'b1;
            end
            RD_LOAD: begin
               state_nxt   = RD_WAIT;
               tx_hold_nxt = reg_rdata;
            end
            RD_WAIT: begin
               if (rx_dv) begin
                  state_nxt = RD_REQ;
                  re_nxt    = 1'b1;
                  if (AUTO_INC != 0) begin
                     addr_nxt = addr_inc;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_bridge
// Purpose  : Self-checking bench for spi_reg_bridge against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_bridge;

   localparam int         AW     = 7;
   localparam int         AINC   = 1;
   localparam logic [7:0] IDLE_B = 8'h00;
   localparam int         NADDR  = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ss  = 1'b1;
   logic [7:0]    rx_byte = 8'h00;
   logic          rx_dv = 1'b0;
   logic [7:0]    tx_byte;
   logic          tx_wr;
   logic [AW-1:0] reg_addr;
   logic [7:0]    reg_wdata;
   logic          reg_we;
   logic          reg_re;
   logic [7:0]    reg_rdata = 8'h00;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int cyc;
      int addr;
      int data;
   } ev_t;

   ev_t        we_log[$];
   ev_t        re_log[$];
   ev_t        tx_log[$];
   logic [7:0] regs[NADDR];
   logic [7:0] fb[8];
   int         rxc[8];

   spi_reg_bridge #(
      .ADDR_WIDTH (AW),
      .AUTO_INC   (AINC),
      .IDLE_BYTE  (IDLE_B)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ss        (ss),
      .rx_byte   (rx_byte),
      .rx_dv     (rx_dv),
      .tx_byte   (tx_byte),
      .tx_wr     (tx_wr),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_we    (reg_we),
      .reg_re    (reg_re),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Register file: synchronous read, data valid the cycle after reg_re.
   always @(posedge clk) begin
      if (reg_re) reg_rdata <= regs[reg_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (reg_we) we_log.push_back('{cyc, int'(reg_addr), int'(reg_wdata)});
         if (reg_re) re_log.push_back('{cyc, int'(reg_addr), 0});
         if (tx_wr)  tx_log.push_back('{cyc, 0, int'(tx_byte)});
         if (reg_we || reg_re) chk("we_re_excl", {31'b0, reg_we & reg_re}, 32'd0);
      end
   end

   task automatic clear_logs();
      we_log.delete();
      re_log.delete();
      tx_log.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, output int c);
      @(posedge clk); #1;
      rx_byte = b;
      rx_dv   = 1'b1;
      c       = cyc;
      @(posedge clk); #1;
      rx_dv   = 1'b0;
      repeat (9) @(posedge clk);
   endtask

   // Drives one framed transaction of n bytes from fb[] and checks it against
   // the frame-level model of what the register port must see.
   task automatic run_frame(input int n);
      int         c0, a, start;
      logic [7:0] cmd;
      clear_logs();
      @(posedge clk); #1;
      ss = 1'b0;
      c0 = cyc;
      repeat (6) @(posedge clk);
      for (int i = 0; i < n; i++) send_byte(fb[i], rxc[i]);
      #1 chk("busy_in_frame", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
      ss = 1'b1;
      repeat (6) @(posedge clk);
      #1 chk("busy_after_frame", {31'b0, busy}, 32'd0);

      cmd   = fb[0];
      start = int'(cmd[AW-1:0]);
      if (tx_log.size() > 0) begin
         chk("idle_byte", tx_log[0].data, IDLE_B);
         chk("start_lat", ((tx_log[0].cyc - c0) >= 2 && (tx_log[0].cyc - c0) <= 4) ? 1 : 0, 1);
      end
      if (cmd[7]) begin
         chk("tx_count", tx_log.size(), 1);
         chk("re_count", re_log.size(), 0);
         chk("we_count", we_log.size(), n - 1);
         for (int i = 1; i < n; i++) begin
            a = (start + (AINC != 0 ? i - 1 : 0)) % NADDR;
            if (i - 1 < we_log.size()) begin
               chk("we_addr", we_log[i-1].addr, a);
               chk("we_data", we_log[i-1].data, fb[i]);
               chk("we_cyc",  we_log[i-1].cyc,  rxc[i] + 1);
            end
            regs[a] = fb[i];
         end
      end else begin
         chk("we_count", we_log.size(), 0);
         chk("re_count", re_log.size(), n);
         chk("tx_count", tx_log.size(), n + 1);
         for (int i = 0; i < n; i++) begin
            a = (start + (AINC != 0 ? i : 0)) % NADDR;
            if (i < re_log.size()) begin
               chk("re_addr", re_log[i].addr, a);
               chk("re_cyc",  re_log[i].cyc,  rxc[i] + 1);
            end
            if (i + 1 < tx_log.size()) begin
               chk("tx_data", tx_log[i+1].data, regs[a]);
               chk("tx_cyc",  tx_log[i+1].cyc,  rxc[i] + 2);
            end
         end
      end
   endtask

   initial begin
      int         c;
      int         n;
      logic [6:0] ra;
      for (int i = 0; i < NADDR; i++) regs[i] = 8'($urandom);

      repeat (3) @(posedge clk);
      #1 chk("reset_outputs", {5'b0, tx_byte, tx_wr, reg_addr, reg_wdata, reg_we, reg_re, busy}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);

      // Write burst
      fb[0] = 8'h83; fb[1] = 8'h12; fb[2] = 8'h34;
      run_frame(3);

      // Read burst
      regs[5] = 8'hAA; regs[6] = 8'h55;
      fb[0] = 8'h05; fb[1] = 8'h00; fb[2] = 8'h00;
      run_frame(3);

      // Address wrap
      fb[0] = 8'hFF; fb[1] = 8'h11; fb[2] = 8'h22;
      run_frame(3);

      // Abort after the command byte, then a fresh frame
      fb[0] = 8'hA0;
      run_frame(1);
      fb[0] = 8'h20; fb[1] = 8'h00;
      run_frame(2);

      // Asynchronous reset in the middle of a write burst
      clear_logs();
      @(posedge clk); #1;
      ss = 1'b0;
      repeat (6) @(posedge clk);
      send_byte(8'h90, c);
      send_byte(8'h5A, c);
      chk("pre_rst_we_count", we_log.size(), 1);
      if (we_log.size() > 0) begin
         chk("pre_rst_we_addr", we_log[0].addr, 32'h10);
         chk("pre_rst_we_data", we_log[0].data, 32'h5A);
      end
      regs[7'h10] = 8'h5A;
      @(posedge clk); #3;
      rst = 1'b1;
      #1 chk("async_rst_outputs", {5'b0, tx_byte, tx_wr, reg_addr, reg_wdata, reg_we, reg_re, busy}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      clear_logs();
      repeat (4) @(posedge clk);
      send_byte(8'h91, c);
      send_byte(8'h22, c);
      chk("post_rst_strobes", we_log.size() + re_log.size() + tx_log.size(), 0);
      chk("post_rst_busy", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      ss = 1'b1;
      repeat (6) @(posedge clk);

      // Randomized frames
      for (int f = 0; f < 16; f++) begin
         n  = $urandom_range(1, 5);
         ra = 7'($urandom);
         if (f % 4 == 3) ra = 7'h7E;
         fb[0] = {1'($urandom), ra};
         for (int i = 1; i < n; i++) fb[i] = 8'($urandom);
         run_frame(n);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
